// File: rtl/psum_acc_seq.sv
// Sequencer that pops column partial sums from the systolic-array OFIFO and feeds
// them to the SFU accumulator, walking every entry once per pass for n_pass passes.
module psum_acc_seq #(
  parameter int psum_bw     = 16,
  parameter int NUM_ENTRIES = 16,
  parameter int SEL_W       = 4,
  parameter int PASS_W      = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [PASS_W-1:0]         n_pass,
  input  logic                      fifo_valid,
  input  logic [psum_bw-1:0]        fifo_rdata,
  output logic                      fifo_rd,
  output logic signed [psum_bw-1:0] psum_out,
  output logic                      acc,
  output logic [SEL_W-1:0]          sel_line,
  output logic                      first_pass,
  output logic                      busy,
  output logic                      done,
  output logic [1:0]                dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [SEL_W-1:0] LAST_ENTRY = SEL_W'(NUM_ENTRIES - 1);

  state_t              state;
  logic [SEL_W-1:0]    entry_cnt;
  logic [PASS_W-1:0]   pass_cnt;
  logic [PASS_W-1:0]   n_pass_q;
  logic                flush_cnt;

  logic                pop_d;
  logic [SEL_W-1:0]    pop_sel;
  logic                pop_first;

  // Handshake: a word is popped in every RUN cycle where fifo_valid is high
  // (fifo_rd && fifo_valid); its data appears on fifo_rdata one cycle later.
  assign fifo_rd   = (state == S_RUN) && fifo_valid;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      entry_cnt <= '0;
      pass_cnt  <= '0;
      n_pass_q  <= '0;
      flush_cnt <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            n_pass_q  <= n_pass;
            entry_cnt <= '0;
            pass_cnt  <= '0;
            if (n_pass != '0) begin
              state <= S_RUN;
              busy  <= 1'b1;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (fifo_rd) begin
            if (entry_cnt == LAST_ENTRY) begin
              entry_cnt <= '0;
              if (pass_cnt == n_pass_q - PASS_W'(1)) begin
                state     <= S_FLUSH;
                flush_cnt <= 1'b0;
              end else begin
                pass_cnt <= pass_cnt + PASS_W'(1);
              end
            end else begin
              entry_cnt <= entry_cnt + SEL_W'(1);
            end
          end
        end
        S_FLUSH: begin
          // Two cycles let the final pop travel through both pipeline stages.
          if (flush_cnt) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            flush_cnt <= 1'b1;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage 1 remembers which entry/pass a pop belonged to while its data is in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pop_d      <= 1'b0;
      pop_sel    <= '0;
      pop_first  <= 1'b0;
      acc        <= 1'b0;
      psum_out   <= '0;
      sel_line   <= '0;
      first_pass <= 1'b0;
    end else begin
      pop_d <= fifo_rd;
      if (fifo_rd) begin
        pop_sel   <= entry_cnt;
        pop_first <= (pass_cnt == '0);
      end
      acc        <= pop_d;
      first_pass <= pop_d & pop_first;
      if (pop_d) begin
        psum_out <= fifo_rdata;
        sel_line <= pop_sel;
      end
    end
  end

endmodule

// File: tb/tb_psum_acc_seq.sv
// Directed bench for psum_acc_seq: models the OFIFO read latency and scores every
// accumulate pulse against an expected queue of {first_pass, sel_line, psum_out}.
module tb_psum_acc_seq;

  localparam int PSUM_BW = 16;
  localparam int NE      = 16;
  localparam int SEL_W   = 4;
  localparam int PASS_W  = 4;
  localparam int EW      = 1 + SEL_W + PSUM_BW;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [PASS_W-1:0]   n_pass;
  logic                fifo_valid;
  logic [PSUM_BW-1:0]  fifo_rdata;
  logic                fifo_rd;
  logic [PSUM_BW-1:0]  psum_out;
  logic                acc;
  logic [SEL_W-1:0]    sel_line;
  logic                first_pass;
  logic                busy;
  logic                done;
  logic [1:0]          dbg_state;

  logic [EW-1:0]       exp_q[$];
  logic [PSUM_BW-1:0]  src_q[$];

  int checks = 0, errors = 0, cyc = 0;
  int pop_cnt = 0, acc_cnt = 0, done_cnt = 0;
  int first_pop = -1, first_acc = -1, last_pop = -1, last_acc = -1, done_cyc = -1;
  int start_cyc = 0;
  int a0, p0, d0;

  always #5 clk = ~clk;

  psum_acc_seq #(.psum_bw(PSUM_BW), .NUM_ENTRIES(NE), .SEL_W(SEL_W), .PASS_W(PASS_W)) dut (
    .clk(clk), .reset(reset), .start(start), .n_pass(n_pass),
    .fifo_valid(fifo_valid), .fifo_rdata(fifo_rdata), .fifo_rd(fifo_rd),
    .psum_out(psum_out), .acc(acc), .sel_line(sel_line), .first_pass(first_pass),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push_exp(input logic f, input int sel, input logic [PSUM_BW-1:0] d);
    exp_q.push_back({f, SEL_W'(sel), d});
    src_q.push_back(d);
  endtask

  // One clock: sample outputs on the falling edge, then model the OFIFO data return.
  task automatic tick();
    logic pend;
    @(negedge clk);
    pend = fifo_rd;
    if (!fifo_valid) chk("rd_without_valid", 32'(fifo_rd), 32'd0);
    if (fifo_rd) begin
      pop_cnt++;
      last_pop = cyc;
      if (first_pop < 0) first_pop = cyc;
    end
    if (acc) begin
      acc_cnt++;
      last_acc = cyc;
      if (first_acc < 0) first_acc = cyc;
      if (exp_q.size() == 0) chk("acc_extra", 32'(acc), 32'd0);
      else chk("acc_entry", 32'({first_pass, sel_line, psum_out}), 32'(exp_q.pop_front()));
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      chk("busy_at_done", 32'(busy), 32'd0);
    end
    @(posedge clk);
    cyc++;
    #1;
    if (pend) fifo_rdata = (src_q.size() != 0) ? src_q.pop_front() : 16'hDEAD;
  endtask

  // vm=1 gives the 1,0,0 fifo_valid pattern; repulse re-fires start mid-job.
  task automatic run_job(input int np, input int vm, input int repulse, input int budget);
    int k, cnt, dbase;
    first_pop = -1;
    first_acc = -1;
    dbase     = done_cnt;
    k         = 0;
    start_cyc = cyc;
    n_pass     = PASS_W'(np);
    start      = 1'b1;
    fifo_valid = (vm == 0) || (k % 3 == 0);
    tick();
    k++;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'(np != 0));
    cnt = 0;
    while (done_cnt == dbase && cnt < budget) begin
      fifo_valid = (vm == 0) || (k % 3 == 0);
      if (repulse != 0 && cnt == 5) begin
        start  = 1'b1;
        n_pass = PASS_W'(4);
      end else begin
        start = 1'b0;
      end
      tick();
      k++;
      cnt++;
    end
    start = 1'b0;
    if (done_cnt == dbase) chk("done_timeout", 32'(done_cnt - dbase), 32'd1);
    fifo_valid = 1'b1;
    repeat (3) tick();
    fifo_valid = 1'b0;
  endtask

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    n_pass     = '0;
    fifo_valid = 1'b0;
    fifo_rdata = '0;

    // Reset state, then idle with data available: no pops without a start.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fifo_rd",    32'(fifo_rd),    32'd0);
    chk("rst_acc",        32'(acc),        32'd0);
    chk("rst_psum",       32'(psum_out),   32'd0);
    chk("rst_sel",        32'(sel_line),   32'd0);
    chk("rst_first_pass", 32'(first_pass), 32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_done",       32'(done),       32'd0);
    reset      = 1'b1;
    fifo_valid = 1'b1;
    p0 = pop_cnt;
    repeat (5) tick();
    chk("idle_no_pop", 32'(pop_cnt - p0), 32'd0);
    fifo_valid = 1'b0;

    // Single pass, data 100..115.
    for (int i = 0; i < NE; i++) push_exp(1'b1, i, PSUM_BW'(100 + i));
    a0 = acc_cnt; p0 = pop_cnt; d0 = done_cnt;
    run_job(1, 0, 0, 200);
    chk("p1_pops",        32'(pop_cnt - p0),          32'd16);
    chk("p1_accs",        32'(acc_cnt - a0),          32'd16);
    chk("p1_done_cnt",    32'(done_cnt - d0),         32'd1);
    chk("p1_first_pop",   32'(first_pop - start_cyc), 32'd1);
    chk("p1_acc_latency", 32'(first_acc - first_pop), 32'd2);
    chk("p1_acc_burst",   32'(last_acc - first_acc),  32'd15);
    chk("p1_pop_burst",   32'(last_pop - first_pop),  32'd15);
    chk("p1_done_vs_pop", 32'(done_cyc - last_pop),   32'd3);
    chk("p1_done_vs_acc", 32'(done_cyc - last_acc),   32'd1);
    chk("p1_exp_empty",   32'(exp_q.size()),          32'd0);

    // Three passes of -5.
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < NE; i++) push_exp(p == 0, i, 16'hFFFB);
    a0 = acc_cnt; d0 = done_cnt;
    run_job(3, 0, 0, 300);
    chk("p3_accs",      32'(acc_cnt - a0),  32'd48);
    chk("p3_done_cnt",  32'(done_cnt - d0), 32'd1);
    chk("p3_exp_empty", 32'(exp_q.size()),  32'd0);

    // Stalling FIFO: valid high one cycle in three.
    for (int i = 0; i < NE; i++) push_exp(1'b1, i, PSUM_BW'(16'h0400 + i));
    a0 = acc_cnt; p0 = pop_cnt; d0 = done_cnt;
    run_job(1, 1, 0, 300);
    chk("stall_pops",      32'(pop_cnt - p0),  32'd16);
    chk("stall_accs",      32'(acc_cnt - a0),  32'd16);
    chk("stall_done_cnt",  32'(done_cnt - d0), 32'd1);
    chk("stall_exp_empty", 32'(exp_q.size()),  32'd0);

    // Zero passes: immediate done, no traffic.
    a0 = acc_cnt; p0 = pop_cnt; d0 = done_cnt;
    run_job(0, 0, 0, 20);
    chk("zero_done_cnt", 32'(done_cnt - d0),         32'd1);
    chk("zero_done_lat", 32'(done_cyc - start_cyc),  32'd1);
    chk("zero_pops",     32'(pop_cnt - p0),          32'd0);
    chk("zero_accs",     32'(acc_cnt - a0),          32'd0);

    // Two passes with a start re-pulse (n_pass=4) while running.
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < NE; i++) push_exp(p == 0, i, PSUM_BW'(16'h0200 + 16 * p + i));
    a0 = acc_cnt; d0 = done_cnt;
    run_job(2, 0, 1, 300);
    chk("restart_accs",      32'(acc_cnt - a0),  32'd32);
    chk("restart_done_cnt",  32'(done_cnt - d0), 32'd1);
    chk("restart_exp_empty", 32'(exp_q.size()),  32'd0);

    // Abort with reset while entry 7 of pass 1 is being popped.
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < NE; i++) push_exp(p == 0, i, PSUM_BW'(16'h0500 + 16 * p + i));
    a0 = acc_cnt;
    n_pass     = PASS_W'(2);
    start      = 1'b1;
    fifo_valid = 1'b1;
    tick();
    start = 1'b0;
    repeat (23) tick();
    chk("abort_accs_before", 32'(acc_cnt - a0), 32'd21);
    chk("abort_rd_live",     32'(fifo_rd),      32'd1);
    chk("abort_sel_live",    32'(sel_line),     32'd5);
    reset = 1'b0;
    #1;
    chk("abort_acc",     32'(acc),       32'd0);
    chk("abort_fifo_rd", 32'(fifo_rd),   32'd0);
    chk("abort_busy",    32'(busy),      32'd0);
    chk("abort_state",   32'(dbg_state), 32'd0);
    repeat (3) begin
      tick();
      chk("abort_hold_psum", 32'(psum_out),   32'd0);
      chk("abort_hold_sel",  32'(sel_line),   32'd0);
      chk("abort_hold_fp",   32'(first_pass), 32'd0);
      chk("abort_hold_done", 32'(done),       32'd0);
    end
    exp_q.delete();
    src_q.delete();
    reset      = 1'b1;
    fifo_valid = 1'b0;
    tick();

    for (int i = 0; i < NE; i++) push_exp(1'b1, i, PSUM_BW'(16'h0300 + i));
    a0 = acc_cnt; d0 = done_cnt;
    run_job(1, 0, 0, 200);
    chk("after_abort_accs",      32'(acc_cnt - a0),  32'd16);
    chk("after_abort_done_cnt",  32'(done_cnt - d0), 32'd1);
    chk("after_abort_exp_empty", 32'(exp_q.size()),  32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
